game_scroll_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 44 ++++
 rtl/game_step_timer.sv | 32 +++
 rtl/game_scroll_ctrl.sv | 124 ++++++++++++
 tb/tb_game_scroll_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the horizontal map scroller.
//   - scroll_state_t : states of the scroll sequencer
//   - zone boundaries (pixels) and zone targets (offset units)
//   - OFS_MAX_DEF    : default maximum map offset
//   - zone_tgt()     : player-follow target lookup with a hysteresis band
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } scroll_state_t;

  localparam logic [10:0] ZONE_B0 = 11'd400;
  localparam logic [10:0] ZONE_B1 = 11'd512;
  localparam logic [10:0] ZONE_B2 = 11'd800;
  localparam logic [10:0] ZONE_B3 = 11'd1200;
  localparam logic [10:0] ZONE_B4 = 11'd1600;

  localparam logic [7:0] ZONE_T0 = 8'd0;
  localparam logic [7:0] ZONE_T1 = 8'd64;
  localparam logic [7:0] ZONE_T2 = 8'd128;
  localparam logic [7:0] ZONE_T3 = 8'd192;

  localparam logic [7:0] OFS_MAX_DEF = 8'd250;

  // Positions in 400..512 and exactly on 800/1200/1600 keep the previous
  // target, so a player hovering on a boundary does not make the map jitter.
  function automatic logic [7:0] zone_tgt(input logic [10:0] pos,
                                          input logic [7:0]  prev,
                                          input logic [7:0]  ofs_max);
    logic [7:0] t;
    t = prev;
    if (pos < ZONE_B0)                         t = ZONE_T0;
    else if ((pos > ZONE_B1) && (pos < ZONE_B2)) t = ZONE_T1;
    else if ((pos > ZONE_B2) && (pos < ZONE_B3)) t = ZONE_T2;
    else if ((pos > ZONE_B3) && (pos < ZONE_B4)) t = ZONE_T3;
    else if (pos > ZONE_B4)                    t = ofs_max;
    if (t > ofs_max) t = ofs_max;
    return t;
  endfunction

endpackage

// File: rtl/game_step_timer.sv
// game_step_timer
// Pacing counter for the scroll sequencer: counts 0..STEP_DIV-1 and wraps.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : restart the count at 0 on the next edge
//   tc    : high for the single cycle the count sits at STEP_DIV-1
module game_step_timer #(
  parameter int STEP_DIV = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(STEP_DIV - 1);

  logic [W-1:0] count;

  // Free-running wrap counter; clr takes priority so a fresh interval always
  // starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (clr)            count <= '0;
    else if (count == LAST)  count <= '0;
    else                     count <= count + 1'b1;
  end

  assign tc = (count == LAST) && !clr;

endmodule

// File: rtl/game_scroll_ctrl.sv
// game_scroll_ctrl
// Steps the horizontal map offset toward a target, one unit per interval of
// STEP_DIV+1 clocks. The target comes from the player-follow zones or, with
// priority, from a forced request.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   player_pos     : player world x in pixels
//   req_valid      : forced scroll request (held until accepted)
//   req_target     : forced target offset (clamped to OFS_MAX)
//   req_ready      : high in IDLE; request accepted when both are high
//   map_ofset      : current map offset
//   player_pos_out : player screen x (world x minus offset in pixels, floor 0)
//   scrolling      : registered map_ofset != target
//   done_pulse     : one-cycle pulse when a forced scroll finishes
module game_scroll_ctrl
  import game_pkg::*;
#(
  parameter int         STEP_DIV = 2000000,
  parameter logic [7:0] OFS_MAX  = OFS_MAX_DEF,
  parameter int         PX_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] player_pos,
  input  logic        req_valid,
  input  logic [7:0]  req_target,
  output logic        req_ready,
  output logic [7:0]  map_ofset,
  output logic [10:0] player_pos_out,
  output logic        scrolling,
  output logic        done_pulse
);

  scroll_state_t state, state_next;
  logic [7:0]    target, target_next;
  logic [7:0]    ofs_next;
  logic [7:0]    zone;
  logic [7:0]    tgt_eval;
  logic          forced, forced_next;
  logic          done_next;
  logic          timer_clr;
  logic          tc;
  logic [10:0]   ofs_px;

  game_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .tc    (tc)
  );

  assign zone      = zone_tgt(player_pos, target, OFS_MAX);
  assign req_ready = rst_n && (state == IDLE);
  assign ofs_px    = 11'(map_ofset) << PX_SHIFT;

  // Next-state logic. A forced request owns the target until its done pulse;
  // otherwise the zone lookup is re-evaluated in IDLE and at every interval end.
  always_comb begin
    state_next  = state;
    target_next = target;
    forced_next = forced;
    ofs_next    = map_ofset;
    done_next   = 1'b0;
    timer_clr   = 1'b0;
    tgt_eval    = target;
    case (state)
      IDLE: begin
        if (req_valid) begin
          target_next = (req_target > OFS_MAX) ? OFS_MAX : req_target;
          forced_next = 1'b1;
          state_next  = STEP;
        end else begin
          target_next = zone;
          if (zone != map_ofset) state_next = STEP;
        end
      end
      STEP: begin
        if (map_ofset < target)      ofs_next = map_ofset + 8'd1;
        else if (map_ofset > target) ofs_next = map_ofset - 8'd1;
        timer_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (tc) begin
          tgt_eval    = forced ? target : zone;
          target_next = tgt_eval;
          if (map_ofset == tgt_eval) begin
            state_next = IDLE;
            if (forced) begin
              done_next   = 1'b1;
              forced_next = 1'b0;
            end
          end else begin
            state_next = STEP;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any scroll in flight, including
  // a pending forced request, so no done pulse follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      target         <= '0;
      forced         <= 1'b0;
      map_ofset      <= '0;
      done_pulse     <= 1'b0;
      scrolling      <= 1'b0;
      player_pos_out <= '0;
    end else begin
      state          <= state_next;
      target         <= target_next;
      forced         <= forced_next;
      map_ofset      <= ofs_next;
      done_pulse     <= done_next;
      scrolling      <= (map_ofset != target);
      player_pos_out <= (player_pos < ofs_px) ? 11'd0 : (player_pos - ofs_px);
    end
  end

endmodule

// File: tb/tb_game_scroll_ctrl.sv
// tb_game_scroll_ctrl
// Self-checking bench for game_scroll_ctrl with a short pacing interval.
// Expected offset steps are queued as each scroll is started and popped by a
// monitor whenever map_ofset changes.
module tb_game_scroll_ctrl;

  localparam int STEP_DIV = 4;
  localparam int GAP      = STEP_DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] player_pos = 11'd100;
  logic        req_valid = 1'b0;
  logic [7:0]  req_target = 8'd0;
  logic        req_ready;
  logic [7:0]  map_ofset;
  logic [10:0] player_pos_out;
  logic        scrolling;
  logic        done_pulse;

  game_scroll_ctrl #(.STEP_DIV(STEP_DIV), .OFS_MAX(8'd250), .PX_SHIFT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .player_pos     (player_pos),
    .req_valid      (req_valid),
    .req_target     (req_target),
    .req_ready      (req_ready),
    .map_ofset      (map_ofset),
    .player_pos_out (player_pos_out),
    .scrolling      (scrolling),
    .done_pulse     (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] pos;
    logic [7:0]  ofs;
    logic [10:0] ppo;
  } vec_t;

  vec_t vecs[11];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   rr_bad = 0;
  int   last_cyc = 0;
  int   model_ofs = 0;
  bit   in_forced = 0;
  bit   gap_chk = 0;
  bit   have_prev = 0;
  logic [7:0] prev_ofs = 8'd0;
  int   exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Step monitor: every offset change must match the next queued value.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ofs  = 8'd0;
      have_prev = 0;
    end else begin
      if (map_ofset != prev_ofs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_step: got %0d, expected %0d", map_ofset, prev_ofs);
        end else begin
          check_output("step_value", int'(map_ofset), exp_q.pop_front());
        end
        if (gap_chk && have_prev) check_output("step_gap", cyc - last_cyc, GAP);
        have_prev = 1;
        last_cyc  = cyc;
        prev_ofs  = map_ofset;
      end
      if (done_pulse) begin
        done_cnt++;
        in_forced = 0;
      end else if (in_forced && req_ready) begin
        rr_bad++;
      end
    end
  end

  task automatic push_steps(input int to);
    while (model_ofs != to) begin
      model_ofs = (model_ofs < to) ? model_ofs + 1 : model_ofs - 1;
      exp_q.push_back(model_ofs);
    end
  endtask

  task automatic wait_settled(input int exp, input int budget, input string name);
    int n = 0;
    while (!(map_ofset == 8'(exp) && req_ready && !scrolling) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, int'(map_ofset), exp);
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, done_cnt - base, 1);
  endtask

  task automatic wait_ofs(input int exp, input int budget, input string name);
    int n = 0;
    while (map_ofset != 8'(exp) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, int'(map_ofset), exp);
  endtask

  task automatic apply_stimulus(input logic [7:0] tgt);
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = tgt;
    check_output("req_ready_idle", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    in_forced = 1;
  endtask

  initial begin
    int base;
    vecs[0]  = '{11'd450,  8'd64,  11'd194};
    vecs[1]  = '{11'd512,  8'd64,  11'd256};
    vecs[2]  = '{11'd1000, 8'd128, 11'd488};
    vecs[3]  = '{11'd1200, 8'd128, 11'd688};
    vecs[4]  = '{11'd1700, 8'd250, 11'd700};
    vecs[5]  = '{11'd1600, 8'd250, 11'd600};
    vecs[6]  = '{11'd1400, 8'd192, 11'd632};
    vecs[7]  = '{11'd800,  8'd192, 11'd32};
    vecs[8]  = '{11'd700,  8'd64,  11'd444};
    vecs[9]  = '{11'd300,  8'd0,   11'd300};
    vecs[10] = '{11'd100,  8'd0,   11'd100};

    // Reset state, then quiet IDLE with the player in zone 0.
    #3;
    check_output("rst_ofs", int'(map_ofset), 0);
    check_output("rst_ppo", int'(player_pos_out), 0);
    check_output("rst_ready", int'(req_ready), 0);
    check_output("rst_scroll", int'(scrolling), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_output("idle_ofs", int'(map_ofset), 0);
    check_output("idle_ppo", int'(player_pos_out), 100);
    check_output("idle_ready", int'(req_ready), 1);
    check_output("idle_done", done_cnt, 0);

    // Zone follow to 64 with step spacing checked.
    have_prev = 0;
    gap_chk   = 1;
    push_steps(64);
    player_pos = 11'd600;
    repeat (3) @(negedge clk);
    check_output("scrolling_hi", int'(scrolling), 1);
    wait_settled(64, 400, "follow_64");
    gap_chk = 0;
    check_output("follow_ppo", int'(player_pos_out), 344);
    check_output("follow_scroll", int'(scrolling), 0);

    // Table of zone positions including the hysteresis band.
    for (int i = 0; i < 11; i++) begin
      push_steps(int'(vecs[i].ofs));
      player_pos = vecs[i].pos;
      repeat (3) @(negedge clk);
      wait_settled(int'(vecs[i].ofs), 1400, "vec_ofs");
      repeat (10) @(negedge clk);
      check_output("vec_hold", int'(map_ofset), int'(vecs[i].ofs));
      check_output("vec_ppo", int'(player_pos_out), int'(vecs[i].ppo));
    end

    // Forced 255 clamps to 250 against zone 0, then zone follow returns to 0.
    base = done_cnt;
    rr_bad = 0;
    push_steps(250);
    push_steps(0);
    apply_stimulus(8'd255);
    wait_ofs(30, 300, "forced_30");
    @(negedge clk);
    check_output("sat_ppo", int'(player_pos_out), 0);
    wait_done(base, 1500, "forced_done");
    check_output("forced_peak", int'(map_ofset), 250);
    check_output("forced_ready_low", rr_bad, 0);
    wait_settled(0, 1500, "return_0");
    check_output("forced_one_done", done_cnt - base, 1);

    // Forced target equal to the current offset still yields one done pulse.
    base = done_cnt;
    apply_stimulus(8'd0);
    wait_done(base, 20, "equal_done");
    repeat (10) @(negedge clk);
    check_output("equal_one_done", done_cnt - base, 1);
    check_output("equal_ofs", int'(map_ofset), 0);

    // Reset mid forced scroll drops the request with no done pulse.
    player_pos = 11'd300;
    repeat (3) @(negedge clk);
    base = done_cnt;
    push_steps(100);
    apply_stimulus(8'd100);
    wait_ofs(40, 400, "pre_reset_40");
    check_output("pre_reset_ppo", int'(player_pos_out), 144);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_ofs", int'(map_ofset), 0);
    check_output("async_ppo", int'(player_pos_out), 0);
    check_output("async_scroll", int'(scrolling), 0);
    check_output("async_ready", int'(req_ready), 0);
    exp_q.delete();
    model_ofs = 0;
    in_forced = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_output("post_rst_done", done_cnt - base, 0);
    check_output("post_rst_ofs", int'(map_ofset), 0);
    check_output("post_rst_ready", int'(req_ready), 1);
    check_output("post_rst_ppo", int'(player_pos_out), 300);
    check_output("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
